// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: Gray-code exhaustive sweep of an N_IN-input function with truth-table capture/compare (optional STOP_ON_FAIL_EN)
module truth_table_sweeper #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [(1<<N_IN)-1:0]   exp_tt,
  output logic [N_IN-1:0]        stim,
  input  logic                   dut_g,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [N_IN-1:0]        fail_idx,
  output logic [(1<<N_IN)-1:0]   captured
);
  localparam int NV = 1 << N_IN;
  localparam int SW = $clog2(SETTLE + 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] APPLY = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  logic [1:0]      state;
  logic [N_IN:0]   idx;
  logic [SW-1:0]   settle_cnt;
  logic [NV-1:0]   exp_q;
  logic            fail_flag;
  logic            sample;
  logic            last;
  logic            mismatch;
  logic            stop;
  logic [N_IN-1:0] idx_lo;
  logic [N_IN-1:0] gray_n;
  // sample point, end-of-sweep detection and next Gray vector
  always_comb begin
    sample   = (state == APPLY) && (settle_cnt == SW'(SETTLE - 1));
    last     = idx == (N_IN+1)'(NV - 1);
    mismatch = dut_g != exp_q[stim];
    idx_lo   = idx[N_IN-1:0] + 1'b1;
    gray_n   = idx_lo ^ (idx_lo >> 1);
  end
`ifdef STOP_ON_FAIL_EN
  assign stop = fail_flag;
`else
  assign stop = 1'b0;
`endif
  // sweep FSM: start latches the expectation, each vector is held SETTLE cycles then sampled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      settle_cnt <= '0;
      exp_q      <= '0;
      fail_flag  <= 1'b0;
      stim       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_idx   <= '0;
      captured   <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        state      <= APPLY;
        exp_q      <= exp_tt;
        captured   <= '0;
        fail_flag  <= 1'b0;
        fail_idx   <= '0;
        pass       <= 1'b0;
        idx        <= '0;
        settle_cnt <= '0;
        stim       <= '0;
        busy       <= 1'b1;
      end else if (state == APPLY && stop) begin
        state <= DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
        pass  <= 1'b0;
        stim  <= '0;
      end else if (sample) begin
        captured[stim] <= dut_g;
        settle_cnt     <= '0;
        if (mismatch && !fail_flag) begin
          fail_idx  <= stim;
          fail_flag <= 1'b1;
        end
        if (last) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= !(fail_flag || mismatch);
          stim  <= '0;
        end else begin
          idx  <= idx + 1'b1;
          stim <= gray_n;
        end
      end else if (state == APPLY) begin
        settle_cnt <= settle_cnt + 1'b1;
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end
endmodule
